// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit ALU datapath and its command sequencer:
// ALU input-select encodings, the sequencer FSM state type and the one-hot
// operation codes that drive the ALU out_sel pins.
// ---------------------------------------------------------------------------
package alu_pkg;

  // ALU in_sel encodings, {persist, load, reset}
  localparam logic [2:0] SEL_RESET   = 3'b001;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_PERSIST = 3'b100;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_EXEC = 2'b10,
    ST_HOLD = 2'b11
  } state_t;

  // One-hot operation selects (OP_W = 7)
  localparam int         OP_W_DEF = 7;
  localparam logic [6:0] OP_ADD   = 7'b0000001;
  localparam logic [6:0] OP_SUB   = 7'b0000010;
  localparam logic [6:0] OP_AND   = 7'b0000100;
  localparam logic [6:0] OP_OR    = 7'b0001000;
  localparam logic [6:0] OP_XOR   = 7'b0010000;
  localparam logic [6:0] OP_SHL   = 7'b0100000;
  localparam logic [6:0] OP_SHR   = 7'b1000000;

endpackage

// File: rtl/alu_cmd_seq_cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO with registered full/empty flags. A write while full or a
// read while empty is ignored. Pointers wrap naturally (DEPTH power of two).
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   wr_en, wr_data push request and data
//   full           registered: no space left
//   rd_en          pop request
//   rd_data        head entry (valid while !empty)
//   empty          registered: no entries
// ---------------------------------------------------------------------------
module cmd_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = wr_en && !full_r;
  assign pop_s  = rd_en && !empty_r;

  // Occupancy after this cycle's push/pop; simultaneous push+pop keeps it
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!push_s && pop_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, count and registered flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == '0);
    end
  end

  // Storage array; contents need no reset since empty_r guards reads
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;

endmodule

// File: rtl/alu_cmd_seq.sv
// ---------------------------------------------------------------------------
// alu_cmd_seq
// Command sequencer in front of the 8-bit ALU. Commands are buffered in a
// FIFO, then each is applied to the ALU with one LOAD cycle followed by
// PERSIST cycles until the fixed ALU latency has elapsed; the ALU result is
// captured and held on a valid/ready result port.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready = FIFO not full)
//   cmd_num1, cmd_num2, cmd_op   command fields (cmd_op must be one-hot)
//   alu_on, alu_in_sel           ALU enable and {persist, load, reset} select
//   alu_num1, alu_num2           operands to ALU
//   alu_out_sel                  operation to ALU
//   alu_out                      ALU result
//   res_valid/res_ready/res_data result handshake and captured result
//   err_op                       one-cycle pulse: non-one-hot command dropped
//   busy                         FSM active or commands pending
// ---------------------------------------------------------------------------
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 7,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_num1,
  input  logic [DATA_W-1:0] cmd_num2,
  input  logic [OP_W-1:0]   cmd_op,
  output logic              alu_on,
  output logic [2:0]        alu_in_sel,
  output logic [DATA_W-1:0] alu_num1,
  output logic [DATA_W-1:0] alu_num2,
  output logic [OP_W-1:0]   alu_out_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic              err_op,
  output logic              busy
);

  localparam int         CMD_W    = 2*DATA_W + OP_W;
  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT - 1);

  // True when exactly one bit of v is set
  function automatic logic is_onehot(input logic [OP_W-1:0] v);
    return (v != '0) && ((v & (v - OP_W'(1))) == '0);
  endfunction

  state_t            state_r, state_nxt_s;
  logic [2:0]        lat_cnt_r, lat_cnt_nxt_s;
  logic              alu_on_r;
  logic [2:0]        alu_in_sel_r;
  logic [DATA_W-1:0] alu_num1_r, alu_num2_r;
  logic [OP_W-1:0]   alu_out_sel_r;
  logic              res_valid_r, res_valid_nxt_s;
  logic [DATA_W-1:0] res_data_r;
  logic              err_op_r;

  logic              fifo_full_s, fifo_empty_s;
  logic [CMD_W-1:0]  fifo_head_s;
  logic              head_ok_s;
  logic              pop_s, load_cmd_s, capture_s, drop_s;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cmd_valid),
    .wr_data ({cmd_num1, cmd_num2, cmd_op}),
    .full    (fifo_full_s),
    .rd_en   (pop_s),
    .rd_data (fifo_head_s),
    .empty   (fifo_empty_s)
  );

  assign head_ok_s = is_onehot(fifo_head_s[OP_W-1:0]);

  // Next-state, FIFO pop and capture decisions
  always_comb begin
    state_nxt_s     = state_r;
    lat_cnt_nxt_s   = lat_cnt_r;
    res_valid_nxt_s = res_valid_r;
    pop_s           = 1'b0;
    load_cmd_s      = 1'b0;
    capture_s       = 1'b0;
    drop_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
          if (head_ok_s) begin
            load_cmd_s  = 1'b1;
            state_nxt_s = ST_LOAD;
          end else begin
            drop_s      = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        lat_cnt_nxt_s = LAT_INIT;
        state_nxt_s   = ST_EXEC;
      end
      ST_EXEC: begin
        if (lat_cnt_r == 3'd0) begin
          capture_s       = 1'b1;
          res_valid_nxt_s = 1'b1;
          state_nxt_s     = ST_HOLD;
        end else begin
          lat_cnt_nxt_s = lat_cnt_r - 3'd1;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_nxt_s = 1'b0;
          // Back-to-back: go straight to LOAD; a bad head is left for IDLE to drop
          if (!fifo_empty_s && head_ok_s) begin
            pop_s       = 1'b1;
            load_cmd_s  = 1'b1;
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        res_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counter and registered ALU/result outputs (decoded from next state)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      lat_cnt_r     <= 3'd0;
      alu_on_r      <= 1'b0;
      alu_in_sel_r  <= SEL_RESET;
      alu_num1_r    <= '0;
      alu_num2_r    <= '0;
      alu_out_sel_r <= '0;
      res_valid_r   <= 1'b0;
      res_data_r    <= '0;
      err_op_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      lat_cnt_r    <= lat_cnt_nxt_s;
      alu_on_r     <= (state_nxt_s != ST_IDLE);
      alu_in_sel_r <= (state_nxt_s == ST_LOAD) ? SEL_LOAD : SEL_PERSIST;
      if (load_cmd_s) begin
        alu_num1_r    <= fifo_head_s[CMD_W-1 -: DATA_W];
        alu_num2_r    <= fifo_head_s[OP_W +: DATA_W];
        alu_out_sel_r <= fifo_head_s[OP_W-1:0];
      end
      if (capture_s) res_data_r <= alu_out;
      res_valid_r <= res_valid_nxt_s;
      err_op_r    <= drop_s;
    end
  end

  assign cmd_ready   = !fifo_full_s;
  assign alu_on      = alu_on_r;
  assign alu_in_sel  = alu_in_sel_r;
  assign alu_num1    = alu_num1_r;
  assign alu_num2    = alu_num2_r;
  assign alu_out_sel = alu_out_sel_r;
  assign res_valid   = res_valid_r;
  assign res_data    = res_data_r;
  assign err_op      = err_op_r;
  assign busy        = (state_r != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_seq
// Directed bench for alu_cmd_seq. A behavioural ALU (with an explicit
// latency) sits on the ALU pins; a command/result queue model checks every
// load and every held result, and directed literals pin the model.
// dut uses ALU_LAT=1, dut3 uses ALU_LAT=3.
// ---------------------------------------------------------------------------
module tb_alu_cmd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ALU_LAT=1 instance signals
  logic       cmd_valid, cmd_ready, alu_on, res_valid, res_ready, err_op, busy;
  logic [7:0] cmd_num1, cmd_num2, alu_num1, alu_num2, alu_out, res_data;
  logic [6:0] cmd_op, alu_out_sel;
  logic [2:0] alu_in_sel;

  // ALU_LAT=3 instance signals
  logic       cmd_valid_3, cmd_ready_3, alu_on_3, res_valid_3, res_ready_3, err_op_3, busy_3;
  logic [7:0] cmd_num1_3, cmd_num2_3, alu_num1_3, alu_num2_3, alu_out_3, res_data_3;
  logic [6:0] cmd_op_3, alu_out_sel_3;
  logic [2:0] alu_in_sel_3;

  alu_cmd_seq #(.DATA_W(8), .OP_W(7), .DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_num1(cmd_num1), .cmd_num2(cmd_num2), .cmd_op(cmd_op),
    .alu_on(alu_on), .alu_in_sel(alu_in_sel), .alu_num1(alu_num1),
    .alu_num2(alu_num2), .alu_out_sel(alu_out_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .err_op(err_op), .busy(busy)
  );

  alu_cmd_seq #(.DATA_W(8), .OP_W(7), .DEPTH(4), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
    .cmd_num1(cmd_num1_3), .cmd_num2(cmd_num2_3), .cmd_op(cmd_op_3),
    .alu_on(alu_on_3), .alu_in_sel(alu_in_sel_3), .alu_num1(alu_num1_3),
    .alu_num2(alu_num2_3), .alu_out_sel(alu_out_sel_3), .alu_out(alu_out_3),
    .res_valid(res_valid_3), .res_data(res_data_3), .res_ready(res_ready_3),
    .err_op(err_op_3), .busy(busy_3)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural ALU operation
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [6:0] op);
    case (op)
      7'b0000001: return a + b;
      7'b0000010: return a - b;
      7'b0000100: return a & b;
      7'b0001000: return a | b;
      7'b0010000: return a ^ b;
      7'b0100000: return a << b[2:0];
      7'b1000000: return a >> b[2:0];
      default:    return 8'h00;
    endcase
  endfunction

  // Model ALUs: latch on load, output is garbage until the latency has elapsed
  logic [7:0] m_a, m_b, m3_a, m3_b;
  logic [6:0] m_op, m3_op;
  int m_age = 0;
  int m3_age = 0;

  always @(posedge clk) begin
    if (alu_in_sel == 3'b010) begin
      m_a <= alu_num1; m_b <= alu_num2; m_op <= alu_out_sel; m_age <= 1;
    end else if (m_age < 8) begin
      m_age <= m_age + 1;
    end
  end

  always @(posedge clk) begin
    if (alu_in_sel_3 == 3'b010) begin
      m3_a <= alu_num1_3; m3_b <= alu_num2_3; m3_op <= alu_out_sel_3; m3_age <= 1;
    end else if (m3_age < 8) begin
      m3_age <= m3_age + 1;
    end
  end

  assign alu_out   = (m_age  >= 1) ? alu_f(m_a,  m_b,  m_op)  : 8'hEE;
  assign alu_out_3 = (m3_age >= 3) ? alu_f(m3_a, m3_b, m3_op) : 8'hEE;

  // Scoreboard: accepted one-hot commands must be loaded and answered in order
  logic [22:0] load_q[$];
  logic [7:0]  exp_q[$];
  int err_exp = 0;
  int err_seen = 0;
  logic [7:0] last_res = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      load_q.delete();
      exp_q.delete();
    end else begin
      check("in_sel_onehot", $onehot(alu_in_sel), 1);
      if (alu_in_sel == 3'b010) begin
        check("load_pending", load_q.size() > 0, 1);
        if (load_q.size() > 0) begin
          check("load_cmd", {alu_num1, alu_num2, alu_out_sel}, load_q[0]);
          void'(load_q.pop_front());
        end
      end
      if (res_valid) begin
        check("res_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("res_data", res_data, exp_q[0]);
          if (res_ready) void'(exp_q.pop_front());
        end
        if (res_ready) last_res = res_data;
      end
      if (err_op) err_seen++;
      if (cmd_valid && cmd_ready) begin
        if ($onehot(cmd_op)) begin
          load_q.push_back({cmd_num1, cmd_num2, cmd_op});
          exp_q.push_back(alu_f(cmd_num1, cmd_num2, cmd_op));
        end else begin
          err_exp++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] n1, input logic [7:0] n2, input logic [6:0] op);
    bit ok;
    ok = 1'b0;
    cmd_num1 = n1; cmd_num2 = n2; cmd_op = op; cmd_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    check("push_accept", ok, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && !res_valid) begin done = 1'b1; break; end
    end
    check("drain", done, 1);
    step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_sel"}, alu_in_sel, 3'b001);
    check({tag, "_alu_on"}, alu_on, 0);
    check({tag, "_num1"}, alu_num1, 0);
    check({tag, "_out_sel"}, alu_out_sel, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_op"}, err_op, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int err0, rv_cnt, t_load, t_val, exec_cyc;
    rst = 1'b0; res_ready = 1'b1; res_ready_3 = 1'b1;
    cmd_valid = 1'b0; cmd_num1 = 8'h00; cmd_num2 = 8'h00; cmd_op = 7'h00;
    cmd_valid_3 = 1'b0; cmd_num1_3 = 8'h00; cmd_num2_3 = 8'h00; cmd_op_3 = 7'h00;
    step(); step();
    @(negedge clk);
    check_reset_state("reset");
    check("reset_res_valid_3", res_valid_3, 0);
    step();
    rst = 1'b1;
    step();

    // Single command: OR 57|1A = 5F, load next cycle, result 2 cycles after load
    push(8'h57, 8'h1A, 7'b0001000);
    step(); @(negedge clk);
    check("t1_load_sel", alu_in_sel, 3'b010);
    check("t1_num1", alu_num1, 8'h57);
    check("t1_num2", alu_num2, 8'h1A);
    check("t1_out_sel", alu_out_sel, 7'b0001000);
    check("t1_alu_on", alu_on, 1);
    step(); @(negedge clk);
    check("t1_exec_sel", alu_in_sel, 3'b100);
    check("t1_not_yet", res_valid, 0);
    step(); @(negedge clk);
    check("t1_valid", res_valid, 1);
    check("t1_result", res_data, 8'h5F);
    step();
    wait_idle();

    // Five back-to-back commands with the result port stalled
    res_ready = 1'b0;
    push(8'h10, 8'h22, 7'b0000001);
    push(8'h50, 8'h0F, 7'b0000010);
    push(8'hF0, 8'h3C, 7'b0000100);
    push(8'hAA, 8'hFF, 7'b0010000);
    push(8'h03, 8'h02, 7'b0100000);
    @(negedge clk);
    check("t2_full", cmd_ready, 0);
    check("t2_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_hold_valid", res_valid, 1);
      check("t3_hold_data", res_data, 8'h32);
      check("t3_no_load", alu_in_sel, 3'b100);
    end
    step();
    res_ready = 1'b1;
    @(negedge clk);
    check("t3_pre_hs", alu_in_sel, 3'b100);
    @(negedge clk);
    check("t3_load_after_hs", alu_in_sel, 3'b010);
    check("t3_next_num1", alu_num1, 8'h50);
    step();
    wait_idle();
    check("t2_last", last_res, 8'h0C);

    // Non-one-hot command is dropped, the following one executes: 30-05 = 2B
    err0 = err_seen;
    push(8'h11, 8'h22, 7'b0000011);
    push(8'h30, 8'h05, 7'b0000010);
    wait_idle();
    check("t4_err_pulses", err_seen - err0, 1);
    check("t4_result", last_res, 8'h2B);

    // Reset while in EXEC with two commands queued
    push(8'h01, 8'h02, 7'b0000001);
    push(8'h03, 8'h04, 7'b0000001);
    push(8'h05, 8'h06, 7'b0000001);
    rst = 1'b0;
    @(negedge clk);
    check("t5_pre_exec", alu_in_sel, 3'b100);
    check("t5_pre_valid", res_valid, 0);
    step();
    @(negedge clk);
    check_reset_state("t5");
    step();
    rst = 1'b1;
    rv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid) rv_cnt++;
    end
    check("t5_no_result", rv_cnt, 0);
    check("t5_idle", busy, 0);
    step();

    // ALU_LAT=3: ADD 64+23 = 87, LOAD to res_valid exactly 4 cycles
    cmd_num1_3 = 8'h64; cmd_num2_3 = 8'h23; cmd_op_3 = 7'b0000001; cmd_valid_3 = 1'b1;
    @(negedge clk);
    check("t6_ready", cmd_ready_3, 1);
    @(posedge clk);
    #1;
    cmd_valid_3 = 1'b0;
    t_load = -1; t_val = -1; exec_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alu_in_sel_3 == 3'b010 && t_load < 0) t_load = i;
      if (t_load >= 0 && t_val < 0 && alu_in_sel_3 == 3'b100 && !res_valid_3) begin
        exec_cyc++;
        check("t6_num1_stable", alu_num1_3, 8'h64);
        check("t6_num2_stable", alu_num2_3, 8'h23);
        check("t6_op_stable", alu_out_sel_3, 7'b0000001);
        check("t6_on", alu_on_3, 1);
      end
      if (res_valid_3 && t_val < 0) begin
        t_val = i;
        check("t6_result", res_data_3, 8'h87);
      end
    end
    check("t6_latency", t_val - t_load, 4);
    check("t6_exec_cycles", exec_cyc, 3);
    check("t6_no_err", err_op_3, 0);

    check("err_count", err_seen, err_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
